ac_store_unit: RTL and testbench

- Drains accumulator results from a core back to shared data memory. It is the write-out counterpart of the AC load path.
- The control unit presents AC value plus target address. The block buffers it and drives a held-request memory write handshake until the memory acknowledges.
- One instance per core sits between the core's AC/control unit and the memory arbiter port.

---
 rtl/core_pkg.sv | 19 +
 rtl/store_fifo.sv | 53 +++++
 rtl/ac_store_unit.sv | 131 +++++++++++++
 tb/tb_ac_store_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the AC store path: default widths, the store FSM
// state type and the layout of one buffered store entry.
package core_pkg;

  localparam int CORE_ADDR_W = 16;
  localparam int CORE_DATA_W = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } st_state_e;

  // One buffered store at default widths; the FIFO packs {addr, data} in this order.
  typedef struct packed {
    logic [CORE_ADDR_W-1:0] addr;
    logic [CORE_DATA_W-1:0] data;
  } st_entry_t;

endpackage

// File: rtl/store_fifo.sv
// Circular FIFO for pending stores. Pointers carry one extra wrap bit so
// full and empty are distinguished without a separate counter.
module store_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; callers never push when full or pop when empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the buffer.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/ac_store_unit.sv
// AC store unit: buffers accumulator stores from the control unit and drains
// them to memory with a held-request write handshake, in acceptance order.
// Optional macro STORE_TIMEOUT_EN adds a per-entry ack timeout that drops the
// stalled entry and sets a sticky err flag; without it, WRITE waits forever.
//
// state | meaning
// IDLE  | no write outstanding; leaves as soon as the buffer holds an entry
// WRITE | head entry driven on mem_*; pops on ack (or timeout drop)
module ac_store_unit
  import core_pkg::*;
#(
  parameter int ADDR_W  = CORE_ADDR_W,
  parameter int DATA_W  = CORE_DATA_W,
  parameter int DEPTH   = 2
`ifdef STORE_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_ack,
  output logic              busy,
  output logic [15:0]       store_count,
  output logic              err
);

  localparam int EW = ADDR_W + DATA_W;
  localparam int LW = $clog2(DEPTH) + 1;

  st_state_e       state_q, state_d;
  logic [15:0]     count_q, count_d;
  logic            push, pop, ack_hit, drop, wr_active;
  logic            full, empty;
  logic [LW-1:0]   level;
  logic [EW-1:0]   head;

  assign wr_active   = (state_q == WRITE);
  assign st_ready    = !full;
  assign push        = st_valid & !full;
  assign ack_hit     = wr_active & mem_ack;
  assign pop         = ack_hit | drop;
  assign mem_wr_en   = wr_active;
  assign mem_addr    = wr_active ? head[EW-1:DATA_W] : '0;
  assign mem_data    = wr_active ? head[DATA_W-1:0]  : '0;
  assign busy        = !empty | wr_active;
  assign store_count = count_q;

  store_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clock       (clock),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i ({st_addr, st_data}),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .level_o     (level)
  );

  // Next state and completed-write count; a pop of the last entry with no
  // refill in the same cycle returns to IDLE, otherwise the next head follows.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (!empty) state_d = WRITE;
      end
      WRITE: begin
        if (ack_hit) count_d = count_q + 16'd1;
        if (pop && (level == LW'(1)) && !push) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and counter registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

`ifdef STORE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_q, wait_d;
  logic          err_q, err_d;

  // The drop fires in the TIMEOUT-th unacknowledged WRITE cycle of an entry;
  // an ack in that same cycle takes precedence.
  assign drop = wr_active & !mem_ack & (wait_q == CW'(TIMEOUT - 1));
  assign err  = err_q;

  // Wait counter restarts for every new head entry.
  always_comb begin
    err_d = err_q | drop;
    if (!wr_active || pop) wait_d = '0;
    else                   wait_d = wait_q + 1'b1;
  end

  // Timeout registers; err stays set until reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end
`else
  assign drop = 1'b0;
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_ac_store_unit.sv
// Directed bench for ac_store_unit with hand-computed expectations.
module tb_ac_store_unit;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [15:0] st_addr;
  logic [15:0] st_data;
  logic        mem_wr_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_ack;
  logic        busy;
  logic [15:0] store_count;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [31:0] wr_log[$];

  always #5 clock = ~clock;

`ifdef STORE_TIMEOUT_EN
  ac_store_unit #(.ADDR_W(16), .DATA_W(16), .DEPTH(2), .TIMEOUT(4)) dut (
`else
  ac_store_unit #(.ADDR_W(16), .DATA_W(16), .DEPTH(2)) dut (
`endif
    .clock       (clock),
    .rst_n       (rst_n),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_ack     (mem_ack),
    .busy        (busy),
    .store_count (store_count),
    .err         (err)
  );

  // Memory-side record of completed writes, in the order memory saw them.
  always @(posedge clock) begin
    if (rst_n && mem_wr_en && mem_ack) wr_log.push_back({mem_addr, mem_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] d);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
  endtask

  initial begin
    rst_n    = 1'b0;
    mem_ack  = 1'b0;
    drive(1'b0, 16'h0, 16'h0);

    // Reset state
    #12;
    check("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_count", {16'd0, store_count}, 32'd0);
    check("rst_err",   {31'd0, err}, 32'd0);
    check("rst_addr",  {mem_addr, mem_data}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_ready", {31'd0, st_ready}, 32'd1);

    // Single store, ack on the third WRITE cycle
    drive(1'b1, 16'h0010, 16'h1234);
    tick();
    drive(1'b0, 16'h0, 16'h0);
    check("s1_idle_gap", {31'd0, mem_wr_en}, 32'd0);
    check("s1_busy",     {31'd0, busy}, 32'd1);
    for (int c = 1; c <= 3; c++) begin
      tick();
      check($sformatf("s1_wr_en_c%0d", c), {31'd0, mem_wr_en}, 32'd1);
      check($sformatf("s1_fields_c%0d", c), {mem_addr, mem_data}, 32'h0010_1234);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("s1_wr_drop", {31'd0, mem_wr_en}, 32'd0);
    check("s1_count",   {16'd0, store_count}, 32'd1);
    check("s1_busy_end", {31'd0, busy}, 32'd0);

    // Fill and backpressure: A, B fill the buffer, C is held
    drive(1'b1, 16'h0100, 16'hAAAA);
    tick();
    drive(1'b1, 16'h0200, 16'hBBBB);
    check("f_ready_one", {31'd0, st_ready}, 32'd1);
    tick();
    check("f_ready_full", {31'd0, st_ready}, 32'd0);
    drive(1'b1, 16'h0300, 16'hCCCC);
    tick();
    check("f_held_ready", {31'd0, st_ready}, 32'd0);
    check("f_head_a",     {mem_addr, mem_data}, 32'h0100_AAAA);
    // Ack while full with C pending: C must still be refused this cycle
    mem_ack = 1'b1;
    check("f_ack_ready", {31'd0, st_ready}, 32'd0);
    tick();
    mem_ack = 1'b0;
    check("f_after_pop_ready", {31'd0, st_ready}, 32'd1);
    check("f_head_b",          {mem_addr, mem_data}, 32'h0200_BBBB);
    tick();
    drive(1'b0, 16'h0, 16'h0);
    check("f_c_taken_full", {31'd0, st_ready}, 32'd0);
    mem_ack = 1'b1;
    tick();
    check("f_b2b_wr_en", {31'd0, mem_wr_en}, 32'd1);
    check("f_head_c",    {mem_addr, mem_data}, 32'h0300_CCCC);
    tick();
    mem_ack = 1'b0;
    check("f_idle",  {31'd0, mem_wr_en}, 32'd0);
    check("f_count", {16'd0, store_count}, 32'd4);
    check("f_log_n", wr_log.size(), 32'd4);
    if (wr_log.size() == 4) begin
      check("f_order_a", wr_log[1], 32'h0100_AAAA);
      check("f_order_b", wr_log[2], 32'h0200_BBBB);
      check("f_order_c", wr_log[3], 32'h0300_CCCC);
    end

    // Back-to-back drain with ack held high; ack in IDLE must be ignored
    mem_ack = 1'b1;
    drive(1'b1, 16'h0400, 16'hD00D);
    tick();
    drive(1'b1, 16'h0500, 16'hE00E);
    check("b_idle_ack_ignored", {16'd0, store_count}, 32'd4);
    tick();
    drive(1'b0, 16'h0, 16'h0);
    check("b_head_d", {mem_addr, mem_data}, 32'h0400_D00D);
    tick();
    check("b_no_bubble", {31'd0, mem_wr_en}, 32'd1);
    check("b_head_e",    {mem_addr, mem_data}, 32'h0500_E00E);
    tick();
    mem_ack = 1'b0;
    check("b_idle",  {31'd0, mem_wr_en}, 32'd0);
    check("b_count", {16'd0, store_count}, 32'd6);
    check("b_busy",  {31'd0, busy}, 32'd0);

    // Reset in the middle of a write with two entries queued
    drive(1'b1, 16'h0600, 16'h6666);
    tick();
    drive(1'b1, 16'h0700, 16'h7777);
    tick();
    drive(1'b0, 16'h0, 16'h0);
    check("r_pre_wr_en", {31'd0, mem_wr_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("r_async_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("r_async_count", {16'd0, store_count}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    check("r_busy",  {31'd0, busy}, 32'd0);
    check("r_ready", {31'd0, st_ready}, 32'd1);
    check("r_count", {16'd0, store_count}, 32'd0);
    tick();
    tick();
    check("r_dropped", {31'd0, mem_wr_en}, 32'd0);

`ifdef STORE_TIMEOUT_EN
    // No ack: head dropped after 4 WRITE cycles, next entry presented
    drive(1'b1, 16'h0800, 16'h8888);
    tick();
    drive(1'b1, 16'h0900, 16'h9999);
    tick();
    drive(1'b0, 16'h0, 16'h0);
    for (int c = 1; c <= 3; c++) tick();
    check("t_still_h", {mem_addr, mem_data}, 32'h0800_8888);
    check("t_no_err",  {31'd0, err}, 32'd0);
    tick();
    check("t_next_i", {mem_addr, mem_data}, 32'h0900_9999);
    check("t_err",    {31'd0, err}, 32'd1);
    check("t_count",  {16'd0, store_count}, 32'd0);
`else
    check("no_timeout_err", {31'd0, err}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
